// File: rtl/cart_pkg.sv
// Shared types for the PI-bus burst sniffer: FSM states, the captured record layout
// and the halfword pairing rule.
package cart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   localparam int          REC_W   = 66;
   localparam logic [31:0] HW_STEP = 32'd2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        first;
      logic        partial;
   } rec_t;

   // A partial record passes hw1 = 0 so the lone halfword keeps its natural slot.
   function automatic logic [31:0] pair_data(input logic [15:0] hw0,
                                             input logic [15:0] hw1,
                                             input logic        hi_first);
      return hi_first ? {hw0, hw1} : {hw1, hw0};
   endfunction

endpackage

// File: rtl/cart_burst_capture_if.sv
// Record stream from the sniffer to its consumer; valid/ready, head held stable while stalled.
interface cart_burst_capture_if;
   logic        rec_valid;
   logic        rec_ready;
   logic [31:0] rec_addr;
   logic [31:0] rec_data;
   logic        rec_first;
   logic        rec_partial;

   modport master (output rec_valid, rec_addr, rec_data, rec_first, rec_partial,
                   input  rec_ready);
   modport slave  (input  rec_valid, rec_addr, rec_data, rec_first, rec_partial,
                   output rec_ready);
endinterface

// File: rtl/cart_burst_fifo.sv
// Synchronous first-word-fall-through FIFO; push-to-empty deasserts one cycle later.
// A push while full is accepted only when a pop happens in the same cycle.
module cart_burst_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   // Head is forced to zero when empty so the stream reads all-zero out of reset.
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/cart_burst_capture.sv
// Passive N64 PI-bus sniffer: latches the burst base address, samples RD-strobed halfwords
// DATA_DELAY cycles after each synchronised strobe, pairs them into records and queues them.
module cart_burst_capture
   import cart_pkg::*;
#(
   parameter int DATA_DELAY  = 3,
   parameter bit HI_FIRST    = 1'b1,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int DROP_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           cart_ad,
   input  logic                  cart_rd,
   input  logic                  cart_alel,
   input  logic                  cart_aleh,
   cart_burst_capture_if.master  rec,
   output logic                  overflow,
   output logic [DROP_W-1:0]     drop_cnt,
   output logic                  busy
);
   localparam int              TMO_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   // Two-flop synchronisers plus a one-cycle-delayed copy for edge detection.
   logic [15:0] ad_m_q, ad_s_q;
   logic        rd_m_q, rd_s_q, rd_p_q;
   logic        alel_m_q, alel_s_q, alel_p_q;
   logic        aleh_m_q, aleh_s_q, aleh_p_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ad_m_q   <= '0;
         ad_s_q   <= '0;
         rd_m_q   <= 1'b0;
         rd_s_q   <= 1'b0;
         rd_p_q   <= 1'b0;
         alel_m_q <= 1'b0;
         alel_s_q <= 1'b0;
         alel_p_q <= 1'b0;
         aleh_m_q <= 1'b0;
         aleh_s_q <= 1'b0;
         aleh_p_q <= 1'b0;
      end else begin
         ad_m_q   <= cart_ad;
         ad_s_q   <= ad_m_q;
         rd_m_q   <= cart_rd;
         rd_s_q   <= rd_m_q;
         rd_p_q   <= rd_s_q;
         alel_m_q <= cart_alel;
         alel_s_q <= alel_m_q;
         alel_p_q <= alel_s_q;
         aleh_m_q <= cart_aleh;
         aleh_s_q <= aleh_m_q;
         aleh_p_q <= aleh_s_q;
      end
   end

   logic rd_fall, alel_fall, aleh_rise;
   assign rd_fall   = rd_p_q & ~rd_s_q;
   assign alel_fall = alel_p_q & ~alel_s_q;
   assign aleh_rise = ~aleh_p_q & aleh_s_q;

   state_t                state_q, state_d;
   logic [15:0]           addr_hi_q, addr_hi_d;
   logic [15:0]           addr_lo_q, addr_lo_d;
   logic [31:0]           hw_addr_q, hw_addr_d;
   logic                  first_q, first_d;
   logic                  pair_vld_q, pair_vld_d;
   logic [15:0]           pair_hw_q, pair_hw_d;
   logic [31:0]           pair_addr_q, pair_addr_d;
   logic [DATA_DELAY-1:0] dly_q, dly_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

   logic sample, close, push, full, empty, pop, drop;
   rec_t push_rec, head;

   assign sample = dly_q[DATA_DELAY-1];
   assign pop    = rec.rec_valid && rec.rec_ready;
   assign drop   = push && full && !pop;

   always_comb begin
      state_d     = state_q;
      addr_hi_d   = addr_hi_q;
      addr_lo_d   = addr_lo_q;
      hw_addr_d   = hw_addr_q;
      first_d     = first_q;
      pair_vld_d  = pair_vld_q;
      pair_hw_d   = pair_hw_q;
      pair_addr_d = pair_addr_q;
      dly_d       = dly_q;
      tmo_d       = tmo_q;
      close       = 1'b0;
      push        = 1'b0;
      push_rec    = '0;

      case (state_q)
         ST_IDLE: begin
            if (aleh_rise) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (aleh_s_q)      addr_hi_d = ad_s_q;
            else if (alel_s_q) addr_lo_d = ad_s_q;
            if (alel_fall) begin
               state_d    = ST_BURST;
               hw_addr_d  = {addr_hi_q, addr_lo_q};
               first_d    = 1'b1;
               pair_vld_d = 1'b0;
               dly_d      = '0;
               tmo_d      = '0;
            end
         end
         ST_BURST: begin
            dly_d = {dly_q[DATA_DELAY-2:0], rd_fall};
            tmo_d = (rd_fall || sample) ? '0 : tmo_q + TMO_W'(1);
            if (sample) begin
               hw_addr_d = hw_addr_q + HW_STEP;
               if (!pair_vld_q) begin
                  pair_vld_d  = 1'b1;
                  pair_hw_d   = ad_s_q;
                  pair_addr_d = hw_addr_q;
               end else begin
                  push       = 1'b1;
                  push_rec   = '{pair_addr_q, pair_data(pair_hw_q, ad_s_q, HI_FIRST),
                                 first_q, 1'b0};
                  pair_vld_d = 1'b0;
                  first_d    = 1'b0;
               end
            end
            close = aleh_rise || (!rd_fall && !sample && tmo_q == TMO_LAST);
            // A sample landing in the closing cycle is folded in before the flush.
            if (close) begin
               state_d    = aleh_rise ? ST_ADDR : ST_IDLE;
               dly_d      = '0;
               pair_vld_d = 1'b0;
               first_d    = 1'b0;
               if (sample && !pair_vld_q) begin
                  push     = 1'b1;
                  push_rec = '{hw_addr_q, pair_data(ad_s_q, 16'h0, HI_FIRST), first_q, 1'b1};
               end else if (!sample && pair_vld_q) begin
                  push     = 1'b1;
                  push_rec = '{pair_addr_q, pair_data(pair_hw_q, 16'h0, HI_FIRST),
                               first_q, 1'b1};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_hi_q   <= '0;
         addr_lo_q   <= '0;
         hw_addr_q   <= '0;
         first_q     <= 1'b0;
         pair_vld_q  <= 1'b0;
         pair_hw_q   <= '0;
         pair_addr_q <= '0;
         dly_q       <= '0;
         tmo_q       <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_hi_q   <= addr_hi_d;
         addr_lo_q   <= addr_lo_d;
         hw_addr_q   <= hw_addr_d;
         first_q     <= first_d;
         pair_vld_q  <= pair_vld_d;
         pair_hw_q   <= pair_hw_d;
         pair_addr_q <= pair_addr_d;
         dly_q       <= dly_d;
         tmo_q       <= tmo_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   cart_burst_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_rec),
      .full  (full),
      .pop   (pop),
      .dout  (head),
      .empty (empty)
   );

   assign rec.rec_valid   = !empty;
   assign rec.rec_addr    = head.addr;
   assign rec.rec_data    = head.data;
   assign rec.rec_first   = head.first;
   assign rec.rec_partial = head.partial;

   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cart_burst_capture.sv
// Drives one PI bus into two sniffers (hi-first and lo-first pairing) and scoreboards both streams.
module tb_cart_burst_capture;
   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cart_ad = '0;
   logic        cart_rd = 1'b1;
   logic        cart_alel = 1'b0;
   logic        cart_aleh = 1'b0;
   logic        ready = 1'b0;
   logic        ovf_hi, ovf_lo, busy_hi, busy_lo;
   logic [15:0] drop_hi, drop_lo;

   always #5 clk = ~clk;

   cart_burst_capture_if if_hi();
   cart_burst_capture_if if_lo();
   assign if_hi.rec_ready = ready;
   assign if_lo.rec_ready = ready;

   cart_burst_capture #(.DATA_DELAY(3), .HI_FIRST(1'b1), .FIFO_DEPTH(8), .TIMEOUT_CYC(TMO),
                        .DROP_W(16)) dut_hi (
      .clk(clk), .reset(reset), .cart_ad(cart_ad), .cart_rd(cart_rd), .cart_alel(cart_alel),
      .cart_aleh(cart_aleh), .rec(if_hi), .overflow(ovf_hi), .drop_cnt(drop_hi), .busy(busy_hi));

   cart_burst_capture #(.DATA_DELAY(3), .HI_FIRST(1'b0), .FIFO_DEPTH(8), .TIMEOUT_CYC(TMO),
                        .DROP_W(16)) dut_lo (
      .clk(clk), .reset(reset), .cart_ad(cart_ad), .cart_rd(cart_rd), .cart_alel(cart_alel),
      .cart_aleh(cart_aleh), .rec(if_lo), .overflow(ovf_lo), .drop_cnt(drop_lo), .busy(busy_lo));

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        first;
      logic        partial;
   } exp_t;

   exp_t q_hi[$];
   exp_t q_lo[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the record each DUT should produce; full=0 means a lone first halfword.
   task automatic expect_rec(input logic [31:0] addr, input logic [15:0] a,
                             input logic [15:0] b, input bit full, input bit first);
      exp_t e;
      e.addr    = addr;
      e.first   = first;
      e.partial = !full;
      e.data    = full ? {a, b} : {a, 16'h0000};
      q_hi.push_back(e);
      e.data    = full ? {b, a} : {16'h0000, a};
      q_lo.push_back(e);
   endtask

   task automatic pi_addr(input logic [31:0] a);
      cart_alel = 1'b1;
      cart_aleh = 1'b1;
      cart_ad   = a[31:16];
      cyc(4);
      cart_aleh = 1'b0;
      cyc(2);
      cart_ad   = a[15:0];
      cyc(4);
      cart_alel = 1'b0;
      cyc(4);
   endtask

   task automatic rd_pulse(input logic [15:0] hw);
      cart_ad = hw;
      cart_rd = 1'b0;
      cyc(4);
      cart_rd = 1'b1;
      cyc(4);
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (q_hi.size() == 0 && q_lo.size() == 0) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < TMO + 60; i++) begin
         if (!busy_hi && !busy_lo) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   always @(negedge clk) begin
      if (if_hi.rec_valid && ready) begin
         n_checks++;
         if (q_hi.size() == 0) begin
            n_fail++;
            $display("FAIL hi_unexpected_record got addr=%h data=%h", if_hi.rec_addr, if_hi.rec_data);
         end else begin
            exp_t e;
            e = q_hi.pop_front();
            if ({if_hi.rec_addr, if_hi.rec_data, if_hi.rec_first, if_hi.rec_partial} !==
                {e.addr, e.data, e.first, e.partial}) begin
               n_fail++;
               $display("FAIL hi_record got addr=%h data=%h f=%b p=%b want addr=%h data=%h f=%b p=%b",
                        if_hi.rec_addr, if_hi.rec_data, if_hi.rec_first, if_hi.rec_partial,
                        e.addr, e.data, e.first, e.partial);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (if_lo.rec_valid && ready) begin
         n_checks++;
         if (q_lo.size() == 0) begin
            n_fail++;
            $display("FAIL lo_unexpected_record got addr=%h data=%h", if_lo.rec_addr, if_lo.rec_data);
         end else begin
            exp_t e;
            e = q_lo.pop_front();
            if ({if_lo.rec_addr, if_lo.rec_data, if_lo.rec_first, if_lo.rec_partial} !==
                {e.addr, e.data, e.first, e.partial}) begin
               n_fail++;
               $display("FAIL lo_record got addr=%h data=%h f=%b p=%b want addr=%h data=%h f=%b p=%b",
                        if_lo.rec_addr, if_lo.rec_data, if_lo.rec_first, if_lo.rec_partial,
                        e.addr, e.data, e.first, e.partial);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      cyc(2);
      n_checks++;
      if ({if_hi.rec_valid, if_hi.rec_addr, if_hi.rec_data, if_hi.rec_first, if_hi.rec_partial,
           ovf_hi, drop_hi, busy_hi} !== 85'd0) begin
         n_fail++;
         $display("FAIL reset_hi outputs got valid=%b addr=%h data=%h ovf=%b drop=%0d busy=%b want all 0",
                  if_hi.rec_valid, if_hi.rec_addr, if_hi.rec_data, ovf_hi, drop_hi, busy_hi);
      end
      n_checks++;
      if ({if_lo.rec_valid, if_lo.rec_addr, if_lo.rec_data, if_lo.rec_first, if_lo.rec_partial,
           ovf_lo, drop_lo, busy_lo} !== 85'd0) begin
         n_fail++;
         $display("FAIL reset_lo outputs got valid=%b addr=%h data=%h ovf=%b drop=%0d busy=%b want all 0",
                  if_lo.rec_valid, if_lo.rec_addr, if_lo.rec_data, ovf_lo, drop_lo, busy_lo);
      end
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_single_word();
      bit ok;
      ready = 1'b1;
      expect_rec(32'h1000_0040, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
      pi_addr(32'h1000_0040);
      n_checks++;
      if (busy_hi !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy got %b want 1", busy_hi);
      end
      rd_pulse(16'hDEAD);
      rd_pulse(16'hBEEF);
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_drain pending hi=%0d lo=%0d want 0", q_hi.size(), q_lo.size());
      end
      wait_idle(ok);
   endtask

   task automatic test_burst8();
      bit ok;
      for (int i = 0; i < 4; i++)
         expect_rec(32'h1000_0000 + 32'(4 * i), 16'(2 * i + 1), 16'(2 * i + 2), 1'b1, i == 0);
      pi_addr(32'h1000_0000);
      for (int i = 1; i <= 8; i++) rd_pulse(16'(i));
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL burst8_drain pending hi=%0d lo=%0d want 0", q_hi.size(), q_lo.size());
      end
      wait_idle(ok);
   endtask

   task automatic test_odd_timeout();
      bit ok;
      expect_rec(32'h2000_0010, 16'hAAAA, 16'hBBBB, 1'b1, 1'b1);
      expect_rec(32'h2000_0014, 16'hCCCC, 16'h0000, 1'b0, 1'b0);
      pi_addr(32'h2000_0010);
      rd_pulse(16'hAAAA);
      rd_pulse(16'hBBBB);
      rd_pulse(16'hCCCC);
      cyc(TMO - 12);
      n_checks++;
      if ({busy_hi, busy_lo} !== 2'b11) begin
         n_fail++;
         $display("FAIL odd_busy_before_timeout got %b%b want 11", busy_hi, busy_lo);
      end
      n_checks++;
      if (q_lo.size() != 1) begin
         n_fail++;
         $display("FAIL odd_partial_early pending=%0d want 1", q_lo.size());
      end
      wait_idle(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL odd_timeout busy got %b%b want 00", busy_hi, busy_lo);
      end
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL odd_drain pending hi=%0d lo=%0d want 0", q_hi.size(), q_lo.size());
      end
   endtask

   task automatic test_new_aleh();
      bit ok;
      expect_rec(32'h3000_0100, 16'h1111, 16'h0000, 1'b0, 1'b1);
      expect_rec(32'h4000_0200, 16'h2222, 16'h3333, 1'b1, 1'b1);
      pi_addr(32'h3000_0100);
      rd_pulse(16'h1111);
      pi_addr(32'h4000_0200);
      rd_pulse(16'h2222);
      rd_pulse(16'h3333);
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL new_aleh_drain pending hi=%0d lo=%0d want 0", q_hi.size(), q_lo.size());
      end
      wait_idle(ok);
   endtask

   task automatic test_backpressure();
      bit ok;
      ready = 1'b0;
      for (int i = 0; i < 8; i++)
         expect_rec(32'h5000_0000 + 32'(4 * i), 16'h0100 + 16'(2 * i), 16'h0101 + 16'(2 * i),
                    1'b1, i == 0);
      pi_addr(32'h5000_0000);
      for (int i = 0; i < 20; i++) rd_pulse(16'h0100 + 16'(i));
      cyc(8);
      n_checks++;
      if ({ovf_hi, ovf_lo, drop_hi, drop_lo} !== {1'b1, 1'b1, 16'd2, 16'd2}) begin
         n_fail++;
         $display("FAIL bp_overflow got ovf=%b%b drop=%0d/%0d want ovf=11 drop=2/2",
                  ovf_hi, ovf_lo, drop_hi, drop_lo);
      end
      n_checks++;
      if ({if_hi.rec_valid, if_hi.rec_addr, if_hi.rec_data} !== {1'b1, 32'h5000_0000, 32'h0100_0101}) begin
         n_fail++;
         $display("FAIL bp_head_held got valid=%b addr=%h data=%h want 1 50000000 01000101",
                  if_hi.rec_valid, if_hi.rec_addr, if_hi.rec_data);
      end
      ready = 1'b1;
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_drain pending hi=%0d lo=%0d want 0", q_hi.size(), q_lo.size());
      end
      wait_idle(ok);
   endtask

   task automatic test_reset_midflight();
      ready = 1'b1;
      pi_addr(32'h6000_0000);
      rd_pulse(16'h1234);
      cart_ad = 16'h5678;
      cart_rd = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(1);
      n_checks++;
      if ({if_hi.rec_valid, if_hi.rec_addr, if_hi.rec_data, ovf_hi, drop_hi, busy_hi,
           if_lo.rec_valid, ovf_lo, drop_lo, busy_lo} !== 102'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs got valid=%b addr=%h data=%h ovf=%b drop=%0d busy=%b want all 0",
                  if_hi.rec_valid, if_hi.rec_addr, if_hi.rec_data, ovf_hi, drop_hi, busy_hi);
      end
      reset = 1'b0;
      cyc(3);
      cart_rd = 1'b1;
      cyc(20);
      n_checks++;
      if ({if_hi.rec_valid, if_lo.rec_valid, busy_hi, busy_lo} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset_no_record got valid=%b%b busy=%b%b want 0000",
                  if_hi.rec_valid, if_lo.rec_valid, busy_hi, busy_lo);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_burst8();
      test_odd_timeout();
      test_new_aleh();
      test_backpressure();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cart_burst_capture.md
Name: cart_burst_capture

Overview:
Passive sniffer for the N64 cartridge (PI) bus, capturing whole read bursts rather than single words.
- Latches the 32-bit base address from the ALE_H/ALE_L phases.
- Samples every RD-strobed 16-bit halfword after a programmable delay and pairs halfwords into 32-bit records with auto-incremented addresses.
- Pushes records through an internal FIFO to a valid/ready consumer (logger, UART/SPI bridge to the Pi).
- Order mode, delay, FIFO depth and timeout are parametrised; overflow is flagged and counted.

Parameters:
DATA_DELAY, 3, clk cycles from synchronised RD falling edge to halfword sample (must be >= 2)
HI_FIRST, 1, 1: first halfword of a pair goes to data[31:16]; 0: first goes to data[15:0]
FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2
TIMEOUT_CYC, 1024, idle cycles in a burst before the burst is closed
DROP_W, 16, width of saturating drop counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cart_ad  in  16  cartridge AD bus, asynchronous
cart_rd  in  1  cartridge read strobe, active low, asynchronous
cart_alel  in  1  address latch low, asynchronous
cart_aleh  in  1  address latch high, asynchronous
rec_valid  out  1  FIFO head valid
rec_ready  in  1  consumer accepts head when rec_valid && rec_ready
rec_addr  out  32  address of first halfword in record
rec_data  out  32  paired data
rec_first  out  1  record is the first of its burst
rec_partial  out  1  record holds one halfword only; missing half is zero
overflow  out  1  sticky: a record was dropped because the FIFO was full
drop_cnt  out  DROP_W  dropped records, saturating at all-ones
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are 0 on the cycle after reset is high: FIFO empty, FSM IDLE, delay line cleared, overflow=0, drop_cnt=0. Reset mid-burst discards the pending halfword and any in-flight delayed samples.
- Synchroniser: all cart_* inputs pass through 2 flops. Edges are detected on synchronised signals against a one-cycle-delayed copy.
- FSM states:
  - IDLE: on aleh_s rising -> ADDR.
  - ADDR: latch cart_ad_s into addr_hi every cycle while aleh_s=1. Latch into addr_lo every cycle while aleh_s=0 && alel_s=1. On alel_s falling -> BURST; hw_addr <- {addr_hi, addr_lo}; first_flag <- 1; pair empty.
  - BURST:
    - Each RD falling edge shifts a 1 into a DATA_DELAY-long delay line, so overlapping strobes are allowed.
    - When the line output is 1, sample cart_ad_s as one halfword. If the pair is empty, store it and its address. If the pair is full, form a record and push it.
    - Every sample advances hw_addr by 2. Increment wraps modulo 2^32.
    - The timeout counter resets on each RD falling edge and on each sample.
    - aleh_s rising (new address) or timeout expiry closes the burst: flush the pending halfword as a partial record, clear the delay line, then go to ADDR (aleh) or IDLE (timeout).
    - If aleh_s rising and a sample coincide in the same cycle, the sample is taken and included before the flush.
- Pairing: with HI_FIRST=1, data = {hw0, hw1}; with HI_FIRST=0, data = {hw1, hw0}. A partial record places its halfword in the slot it would have occupied and sets the other slot to 0. rec_first=1 only on the first record after entering BURST.
- FIFO:
  - Push-to-rec_valid latency is 1 cycle when empty; total latency is RD negedge + DATA_DELAY + 1 (+2 synchroniser).
  - Simultaneous push and pop while full is accepted and is not counted as a drop.
  - Push while full and no pop: record dropped, overflow <- 1, drop_cnt += 1 (saturating).
  - Outputs are stable while rec_valid && !rec_ready.
- busy = (state != IDLE).

Decomposition:
- Shared package cart_pkg: state encoding (IDLE, ADDR, BURST); record struct/width constant (addr 32 + data 32 + first + partial = 66 bits); PI halfword step constant 2.
- One sub-module, cart_burst_fifo: synchronous FWFT FIFO, parameters WIDTH and DEPTH; ports push/full and pop/empty; count width clog2(DEPTH)+1.
- Synchroniser and FSM stay in the top.

Test Plan:
- Single word: aleh with AD=0x1000, alel with AD=0x0040, two RD pulses with AD=0xDEAD then 0xBEEF, rec_ready=1, HI_FIRST=1 -> one record: addr 0x10000040, data 0xDEADBEEF, first=1, partial=0.
- Burst of 8 halfwords 0x0001..0x0008 at base 0x10000000 -> 4 records at addrs 0x10000000/04/08/0C; data 0x00010002, 0x00030004, 0x00050006, 0x00070008; first set only on the first.
- HI_FIRST=0, odd burst of 3 halfwords 0xAAAA, 0xBBBB, 0xCCCC, then timeout -> 0xBBBBAAAA, then partial record at addr+4 with data 0x0000CCCC; busy drops to 0 at TIMEOUT_CYC.
- Backpressure: rec_ready=0, FIFO_DEPTH=8, 20-halfword burst -> 8 records held, 2 dropped, overflow=1, drop_cnt=2. Release ready -> the first 8 records come out in order.
- New aleh mid-burst after 1 halfword -> partial record flushed before the first record of the new burst; the new base address is used.
- Reset asserted after the RD edge but before DATA_DELAY expires -> no record is produced; all outputs are 0 on the next cycle.
